// File: rtl/fmul_issue_arbiter.sv
// fmul_issue_arbiter: shares one pipelined, non-stallable FMUL among NUM_REQ issue slots.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         per-slot request handshake (ready is the combinational grant)
//   req_a/req_b/req_tag         per-slot operands and tag, slot i in slice i
//   mul_valid/mul_a/mul_b       registered op launched into the FMUL
//   mul_result                  FMUL product, PIPE_LAT cycles after its mul_valid
//   rsp_valid/rsp_ready         result FIFO head handshake
//   rsp_data/rsp_id/rsp_tag     product, originating slot and its tag
module fmul_issue_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_a,
  input  logic [32*NUM_REQ-1:0]      req_b,
  input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
  output logic                       mul_valid,
  output logic [31:0]                mul_a,
  output logic [31:0]                mul_b,
  input  logic [31:0]                mul_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_ptr_q;
  logic             mul_valid_q;
  logic [31:0]      mul_a_q;
  logic [31:0]      mul_b_q;
  logic [ID_W-1:0]  iss_id_q;
  logic [TAG_W-1:0] iss_tag_q;

  // Tag pipeline behind the issue register; last stage lines up with mul_result.
  logic [PIPE_LAT-1:0] sv_q;
  logic [ID_W-1:0]     sid_q  [PIPE_LAT];
  logic [TAG_W-1:0]    stag_q [PIPE_LAT];

  logic [31:0]      fdata_q [FIFO_DEPTH];
  logic [ID_W-1:0]  fid_q   [FIFO_DEPTH];
  logic [TAG_W-1:0] ftag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [CNT_W-1:0] fifo_cnt_d;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  logic            issue_ok_c;
  logic            grant_c;
  logic [ID_W-1:0] grant_id_c;
  logic [ID_W-1:0] idx_c;
  logic            push_c;
  logic            pop_c;

  // Round-robin search starting after the last granted slot, gated by credit.
  always_comb begin
    grant_c    = 1'b0;
    grant_id_c = '0;
    idx_c      = '0;
    req_ready  = '0;
    issue_ok_c = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);
    if (issue_ok_c && !rst) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        idx_c = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
        if (!grant_c && req_valid[idx_c]) begin
          grant_c    = 1'b1;
          grant_id_c = idx_c;
        end
      end
      req_ready[grant_id_c] = grant_c;
    end
  end

  assign push_c = sv_q[PIPE_LAT-1];
  assign pop_c  = rsp_valid && rsp_ready;

  // Credit counters: an op holds a credit from grant until its result leaves the FIFO.
  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    if (grant_c && !push_c) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!grant_c && push_c) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
    if (push_c && !pop_c) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      iss_id_q    <= '0;
      iss_tag_q   <= '0;
      sv_q        <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) begin
        sid_q[k]  <= '0;
        stag_q[k] <= '0;
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fdata_q[k] <= '0;
        fid_q[k]   <= '0;
        ftag_q[k]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
    end else begin
      mul_valid_q <= grant_c;
      if (grant_c) begin
        rr_ptr_q  <= grant_id_c;
        mul_a_q   <= req_a[32*grant_id_c +: 32];
        mul_b_q   <= req_b[32*grant_id_c +: 32];
        iss_id_q  <= grant_id_c;
        iss_tag_q <= req_tag[TAG_W*grant_id_c +: TAG_W];
      end
      sv_q[0]   <= mul_valid_q;
      sid_q[0]  <= iss_id_q;
      stag_q[0] <= iss_tag_q;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        sv_q[k]   <= sv_q[k-1];
        sid_q[k]  <= sid_q[k-1];
        stag_q[k] <= stag_q[k-1];
      end
      if (push_c) begin
        fdata_q[wr_ptr_q] <= mul_result;
        fid_q[wr_ptr_q]   <= sid_q[PIPE_LAT-1];
        ftag_q[wr_ptr_q]  <= stag_q[PIPE_LAT-1];
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Credit makes overflow impossible; catch it if that ever breaks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_c && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
    end
  end

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_data  = fdata_q[rd_ptr_q];
  assign rsp_id    = fid_q[rd_ptr_q];
  assign rsp_tag   = ftag_q[rd_ptr_q];

endmodule
